multicycle_control_fsm: RTL and testbench

- Control-side counterpart of the 16-bit RISC datapath. Consumes the 4-bit opcode the datapath exports and sequences the datapath control strobes over multiple cycles.
- Control strobes driven: jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write, alu_op, plus instruction-register load and PC-enable.
- Adds a data-memory request/ready handshake with wait states and a timeout trap, so memory may be slower than one cycle.

---
 rtl/multicycle_control_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Control sequencer for the 16-bit multicycle RISC datapath. It takes the
//   opcode the datapath exports and walks each instruction through
//   FETCH -> DECODE -> EXEC [-> MEM] [-> WB], driving the datapath strobes.
//   Data memory may take several cycles: MEM holds its request until
//   mem_ready, and traps if memory stays silent for MEM_TIMEOUT cycles.
//
//   Optional build macro: CTRL_PERF_CNT_EN adds retired/stall counters.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   opcode[3:0]     instr[15:12], sampled only in DECODE
//   mem_ready       data memory completes the access this cycle
//   ir_load, pc_en  instruction-register load, PC update (retire)
//   jump, beq, bne  PC-source controls
//   mem_req, mem_read, mem_write   data memory request and direction
//   alu_src, reg_dst, mem_to_reg, reg_write, alu_op[1:0]  datapath muxes
//   state[2:0]      current state (debug)
//   trap            sticky illegal-opcode / memory-timeout flag
//   retired_cnt, stall_cnt [31:0]  only with CTRL_PERF_CNT_EN
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       ir_load,
  output logic       pc_en,
  output logic       jump,
  output logic       beq,
  output logic       bne,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic [2:0] state,
  output logic       trap
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LW  = 4'h0;
  localparam logic [3:0] OP_SW  = 4'h1;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_J   = 4'hD;

  state_t          cur_state;
  state_t          next_state;
  logic [3:0]      opcode_q;
  logic [TO_W-1:0] to_cnt;
  logic            is_rtype_q;
  logic            is_lw_q;
  logic            is_sw_q;
  logic            is_illegal;
  logic            mem_timeout;

  assign is_rtype_q = (opcode_q >= 4'h2) && (opcode_q <= 4'h9);
  assign is_lw_q    = (opcode_q == OP_LW);
  assign is_sw_q    = (opcode_q == OP_SW);
  // DECODE judges the live opcode, since opcode_q is only written on that edge
  assign is_illegal = (opcode == 4'hA) || (opcode == 4'hE) || (opcode == 4'hF);

  // The timeout fires in the MEM cycle whose stall would bring the count to
  // MEM_TIMEOUT; a ready in that same cycle still completes the access.
  generate
    if (MEM_TIMEOUT != 0) begin : g_timeout
      assign mem_timeout = !mem_ready && (to_cnt == TO_W'(MEM_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign mem_timeout = 1'b0;
    end
  endgenerate

  // State, latched opcode and wait-state counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_IDLE;
      opcode_q  <= 4'h0;
      to_cnt    <= '0;
    end else begin
      cur_state <= next_state;
      if (cur_state == S_DECODE) begin
        opcode_q <= opcode;
      end
      // Held at zero outside MEM so every MEM visit starts from a clean count
      if (cur_state != S_MEM) begin
        to_cnt <= '0;
      end else if (!mem_ready) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  // Next-state and strobe decode from registered state and opcode_q
  always_comb begin
    next_state = cur_state;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    jump       = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    trap       = 1'b0;
    case (cur_state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        ir_load    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: next_state = is_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (is_rtype_q) begin
          reg_dst    = 1'b1;
          next_state = S_WB;
        end else begin
          case (opcode_q)
            OP_LW, OP_SW: begin
              alu_op     = 2'b10;
              alu_src    = 1'b1;
              next_state = S_MEM;
            end
            OP_BEQ: begin
              alu_op     = 2'b01;
              beq        = 1'b1;
              pc_en      = 1'b1;
              next_state = S_FETCH;
            end
            OP_BNE: begin
              alu_op     = 2'b01;
              bne        = 1'b1;
              pc_en      = 1'b1;
              next_state = S_FETCH;
            end
            OP_J: begin
              jump       = 1'b1;
              pc_en      = 1'b1;
              next_state = S_FETCH;
            end
            default: next_state = S_TRAP;
          endcase
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        alu_op    = 2'b10;
        alu_src   = 1'b1;
        mem_read  = is_lw_q;
        mem_write = is_sw_q;
        if (mem_ready) begin
          // A store retires in its completing MEM cycle; a load still writes back
          pc_en      = is_sw_q;
          next_state = is_sw_q ? S_FETCH : S_WB;
        end else if (mem_timeout) begin
          next_state = S_TRAP;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_en      = 1'b1;
        mem_to_reg = is_lw_q;
        reg_dst    = !is_lw_q;
        next_state = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

  assign state = cur_state;

`ifdef CTRL_PERF_CNT_EN
  // Counters stop by themselves in TRAP: no pc_en and no MEM cycles there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= 32'd0;
      stall_cnt   <= 32'd0;
    end else begin
      if (pc_en) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if ((cur_state == S_MEM) && !mem_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
//   Self-checking bench for multicycle_control_fsm. Each instruction is
//   expanded by a transaction-level model into its expected per-cycle
//   strobe pattern plus the mem_ready schedule to drive; outputs are compared
//   every cycle, along with latency and pc_en / ir_load totals.
module tb_multicycle_control_fsm;

  localparam int MEM_TIMEOUT = 16;
  localparam int TRAP_HOLD   = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       ir_load, pc_en, jump, beq, bne, mem_req, mem_read, mem_write;
  logic       alu_src, reg_dst, mem_to_reg, reg_write, trap;
  logic [1:0] alu_op;
  logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  typedef struct packed {
    logic       ir_load;
    logic       pc_en;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [2:0] st;
    logic       trap;
  } obs_t;

  obs_t exp_q[$];
  bit   rdy_q[$];

  int total = 0;
  int bad   = 0;
  int pc_en_seen = 0, ir_load_seen = 0;
  int retired_model = 0, fetched_model = 0;
  int perf_ret = 0, perf_stall = 0;

  multicycle_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_en(pc_en), .jump(jump), .beq(beq), .bne(bne),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_op(alu_op), .state(state), .trap(trap)
`ifdef CTRL_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.ir_load    = ir_load;
    o.pc_en      = pc_en;
    o.jump       = jump;
    o.beq        = beq;
    o.bne        = bne;
    o.mem_req    = mem_req;
    o.mem_read   = mem_read;
    o.mem_write  = mem_write;
    o.alu_src    = alu_src;
    o.reg_dst    = reg_dst;
    o.mem_to_reg = mem_to_reg;
    o.reg_write  = reg_write;
    o.alu_op     = alu_op;
    o.st         = state;
    o.trap       = trap;
    return o;
  endfunction

  function automatic obs_t blank(input int st);
    obs_t o;
    o    = '0;
    o.st = st[2:0];
    return o;
  endfunction

  // Latency table, FETCH to FETCH
  function automatic int expLatency(input logic [3:0] op, input int n_mem);
    if (op == 4'h0) return 4 + n_mem;
    if (op == 4'h1) return 3 + n_mem;
    if (op >= 4'h2 && op <= 4'h9) return 4;
    return 3;
  endfunction

  // n_mem = number of MEM cycles (ready on the last); 0 = memory never answers
  function automatic void buildModel(input logic [3:0] op, input int n_mem);
    obs_t o;
    bit   lw, sw, rtype, illegal, rdy;
    int   limit;
    lw      = (op == 4'h0);
    sw      = (op == 4'h1);
    rtype   = (op >= 4'h2 && op <= 4'h9);
    illegal = (op == 4'hA || op == 4'hE || op == 4'hF);
    exp_q.delete();
    rdy_q.delete();
    o = blank(1); o.ir_load = 1'b1;
    exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
    o = blank(2);
    exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
    if (illegal) begin
      for (int k = 0; k < TRAP_HOLD; k++) begin
        o = blank(6); o.trap = 1'b1;
        exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
      end
      return;
    end
    o = blank(3);
    if (rtype) begin
      o.reg_dst = 1'b1;
    end else if (lw || sw) begin
      o.alu_op = 2'b10; o.alu_src = 1'b1;
    end else begin
      o.alu_op = (op == 4'hD) ? 2'b00 : 2'b01;
      o.beq    = (op == 4'hB);
      o.bne    = (op == 4'hC);
      o.jump   = (op == 4'hD);
      o.pc_en  = 1'b1;
    end
    exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
    if (lw || sw) begin
      limit = (n_mem == 0) ? MEM_TIMEOUT : n_mem;
      for (int k = 1; k <= limit; k++) begin
        rdy = (n_mem != 0) && (k == n_mem);
        o = blank(4);
        o.mem_req = 1'b1; o.alu_op = 2'b10; o.alu_src = 1'b1;
        o.mem_read = lw; o.mem_write = sw;
        o.pc_en = rdy && sw;
        exp_q.push_back(o); rdy_q.push_back(rdy);
      end
      if (n_mem == 0) begin
        for (int k = 0; k < TRAP_HOLD; k++) begin
          o = blank(6); o.trap = 1'b1;
          exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
        end
        return;
      end
    end
    if (lw || rtype) begin
      o = blank(5);
      o.reg_write = 1'b1; o.pc_en = 1'b1;
      o.mem_to_reg = lw; o.reg_dst = rtype;
      exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(0, 1)));
    end
  endfunction

  // Runs one instruction (or its first run_cycles cycles when run_cycles > 0)
  task automatic applyStimulus(input logic [3:0] op, input int n_mem, input int run_cycles);
    int   limit, first_pc;
    bit   retiring;
    obs_t got;
    buildModel(op, n_mem);
    limit    = (run_cycles > 0 && run_cycles < exp_q.size()) ? run_cycles : exp_q.size();
    retiring = !(op == 4'hA || op == 4'hE || op == 4'hF) &&
               !((op == 4'h0 || op == 4'h1) && n_mem == 0);
    first_pc = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      mem_ready = rdy_q[i];
      opcode    = (i == 1) ? op : 4'($urandom);
      @(negedge clk);
      got = sample();
      checkOutput($sformatf("op%h_cyc%0d", op, i), 32'(got), 32'(exp_q[i]));
`ifdef CTRL_PERF_CNT_EN
      checkOutput($sformatf("retired_cnt_op%h_cyc%0d", op, i), retired_cnt, 32'(perf_ret));
      checkOutput($sformatf("stall_cnt_op%h_cyc%0d", op, i), stall_cnt, 32'(perf_stall));
`endif
      if (got.pc_en) begin
        pc_en_seen++;
        if (first_pc == 0) first_pc = i + 1;
      end
      if (got.ir_load) ir_load_seen++;
      if (exp_q[i].pc_en) begin
        retired_model++;
        perf_ret++;
      end
      if (exp_q[i].ir_load) fetched_model++;
      if (exp_q[i].st == 3'd4 && !rdy_q[i]) perf_stall++;
    end
    if (limit == exp_q.size() && retiring) begin
      checkOutput($sformatf("latency_op%h_n%0d", op, n_mem), 32'(first_pc), 32'(expLatency(op, n_mem)));
    end
  endtask

  // Asserts reset asynchronously, checks the outputs drop at once, then
  // releases so the FSM sits in IDLE for one cycle before fetching
  task automatic doReset();
    rst       = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    opcode    = 4'($urandom);
    #1;
    checkOutput("rst_async", 32'(sample()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_idle", 32'(sample()), 32'd0);
    perf_ret   = 0;
    perf_stall = 0;
`ifdef CTRL_PERF_CNT_EN
    checkOutput("retired_cnt_rst", retired_cnt, 32'd0);
    checkOutput("stall_cnt_rst", stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    logic [3:0] rop;
    int         r;
    doReset();

    // Directed: one of each class, with wait states and the ready-wins boundary
    applyStimulus(4'h2, 1, 0);
    applyStimulus(4'h0, 4, 0);
    applyStimulus(4'h1, 1, 0);
    applyStimulus(4'hB, 1, 0);
    applyStimulus(4'hC, 1, 0);
    applyStimulus(4'hD, 1, 0);
    applyStimulus(4'h0, MEM_TIMEOUT, 0);
    applyStimulus(4'h1, MEM_TIMEOUT, 0);
    applyStimulus(4'h9, 1, 0);

    // Random legal instruction stream
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 12);
      case (r)
        10:      rop = 4'hB;
        11:      rop = 4'hC;
        12:      rop = 4'hD;
        default: rop = 4'(r);
      endcase
      applyStimulus(rop, $urandom_range(1, 6), 0);
    end

    // Reset in the middle of a load's MEM phase, then refetch
    applyStimulus(4'h0, 5, 5);
    doReset();
    applyStimulus(4'h3, 1, 0);

    // Illegal opcodes trap and stay trapped
    applyStimulus(4'hE, 1, 0);
    doReset();
    applyStimulus(4'hA, 1, 0);
    doReset();
    applyStimulus(4'hF, 1, 0);
    doReset();

    // Memory that never answers
    applyStimulus(4'h0, 0, 0);
    doReset();
    applyStimulus(4'h1, 0, 0);
    doReset();
    applyStimulus(4'h1, 2, 0);

    checkOutput("pc_en_total", 32'(pc_en_seen), 32'(retired_model));
    checkOutput("ir_load_total", 32'(ir_load_seen), 32'(fetched_model));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
